// File: rtl/coh_noc_pkg.sv
// Shared types and constants for the CoH NoC boot-time configuration loader.
package coh_noc_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } cfg_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_VERIFY,
        ST_LOCK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_VERIFY   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    localparam logic [15:0] CFG_SYS_CTRL_ADDR = 16'h0000;
    localparam logic [15:0] CFG_TBL_TERM_ADDR = 16'hFFFF;

endpackage

// File: rtl/coh_noc_cfg_wdog.sv
// Handshake watchdog: counts cycles spent waiting in one state and flags
// expiry when the count reaches TIMEOUT_CYCLES-1.
module coh_noc_cfg_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/coh_noc_cfg_loader.sv
// Boot-table driven config-register programmer with optional readback verify
// (enabled by defining COH_NOC_CFG_LOADER_VERIFY_EN) and a final lock write.
module coh_noc_cfg_loader #(
    parameter int          MAX_ENTRIES    = 256,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          LOCK_ON_DONE   = 1,
    parameter logic [31:0] LOCK_VALUE     = 32'h0000_0005
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           tbl_req,
    output logic [$clog2(MAX_ENTRIES)-1:0] tbl_idx,
    input  logic                           tbl_rvalid,
    input  logic [47:0]                    tbl_data,
    output logic                           cfg_write,
    output logic [15:0]                    cfg_addr,
    output logic [31:0]                    cfg_wdata,
    input  logic [31:0]                    cfg_rdata,
    input  logic                           cfg_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [1:0]                     err_code,
    output logic [$clog2(MAX_ENTRIES)-1:0] err_index,
    output logic [$clog2(MAX_ENTRIES):0]   num_written
);

    import coh_noc_pkg::*;

    localparam int                IDX_W    = $clog2(MAX_ENTRIES);
    localparam int                CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAX_ENTRIES - 1);

    loader_state_t state;
    cfg_entry_t    fetched;
    logic          handshake;
    logic          wd_enable;
    logic          wd_expired;
    logic          last_entry;
    logic          fail;
    logic [1:0]    fail_code;

    assign fetched    = tbl_data;
    assign last_entry = (tbl_idx == LAST_IDX);

    always_comb begin
        handshake = 1'b0;
        wd_enable = 1'b0;
        case (state)
            ST_FETCH: begin
                wd_enable = 1'b1;
                handshake = tbl_rvalid;
            end
            ST_WRITE, ST_VERIFY, ST_LOCK: begin
                wd_enable = 1'b1;
                handshake = cfg_ready;
            end
            default: ;
        endcase
    end

    // A handshake on the expiry edge takes priority over the timeout.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        if (wd_expired && !handshake) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end
`ifdef COH_NOC_CFG_LOADER_VERIFY_EN
        else if (state == ST_VERIFY && handshake) begin
            if (cfg_rdata != cfg_wdata) begin
                fail      = 1'b1;
                fail_code = ERR_VERIFY;
            end else if (last_entry) begin
                fail      = 1'b1;
                fail_code = ERR_OVERFLOW;
            end
        end
`else
        else if (state == ST_WRITE && handshake && last_entry) begin
            fail      = 1'b1;
            fail_code = ERR_OVERFLOW;
        end
`endif
    end

`ifndef COH_NOC_CFG_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^cfg_rdata;
`endif

    coh_noc_cfg_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (handshake),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tbl_req     <= 1'b0;
            tbl_idx     <= '0;
            cfg_write   <= 1'b0;
            cfg_addr    <= '0;
            cfg_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            err_index   <= '0;
            num_written <= '0;
        end else begin
            if (state == ST_WRITE && cfg_ready) begin
                num_written <= num_written + CNT_W'(1);
            end
            if (fail) begin
                state     <= ST_ERROR;
                error     <= 1'b1;
                err_code  <= fail_code;
                err_index <= tbl_idx;
                cfg_write <= 1'b0;
                tbl_req   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (start) begin
                            state       <= ST_FETCH;
                            tbl_req     <= 1'b1;
                            tbl_idx     <= '0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            error       <= 1'b0;
                            err_code    <= ERR_NONE;
                            err_index   <= '0;
                            num_written <= '0;
                        end
                    end
                    ST_FETCH: begin
                        if (tbl_rvalid) begin
                            tbl_req <= 1'b0;
                            if (fetched.addr == CFG_TBL_TERM_ADDR) begin
                                if (LOCK_ON_DONE != 0) begin
                                    state     <= ST_LOCK;
                                    cfg_write <= 1'b1;
                                    cfg_addr  <= CFG_SYS_CTRL_ADDR;
                                    cfg_wdata <= LOCK_VALUE;
                                end else begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                state     <= ST_WRITE;
                                cfg_write <= 1'b1;
                                cfg_addr  <= fetched.addr;
                                cfg_wdata <= fetched.data;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (cfg_ready) begin
                            cfg_write <= 1'b0;
`ifdef COH_NOC_CFG_LOADER_VERIFY_EN
                            state     <= ST_VERIFY;
`else
                            state     <= ST_FETCH;
                            tbl_req   <= 1'b1;
                            tbl_idx   <= tbl_idx + IDX_W'(1);
`endif
                        end
                    end
                    ST_VERIFY: begin
                        if (cfg_ready) begin
                            state   <= ST_FETCH;
                            tbl_req <= 1'b1;
                            tbl_idx <= tbl_idx + IDX_W'(1);
                        end
                    end
                    ST_LOCK: begin
                        if (cfg_ready) begin
                            state     <= ST_DONE;
                            cfg_write <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coh_noc_cfg_loader.sv
// Self-checking bench for coh_noc_cfg_loader: a boot-table/config-target model
// predicts the write sequence and final status of each load.
module tb_coh_noc_cfg_loader;

    localparam int          MAX     = 8;
    localparam int          IDX_W   = $clog2(MAX);
    localparam int          TMO     = 16;
    localparam int          LOCK_ON = 1;
    localparam logic [31:0] LOCKV   = 32'h0000_0005;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              tbl_req;
    logic [IDX_W-1:0]  tbl_idx;
    logic              tbl_rvalid = 1'b0;
    logic [47:0]       tbl_data = '0;
    logic              cfg_write;
    logic [15:0]       cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    logic              cfg_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [IDX_W-1:0]  err_index;
    logic [IDX_W:0]    num_written;

    coh_noc_cfg_loader #(
        .MAX_ENTRIES   (MAX),
        .TIMEOUT_CYCLES(TMO),
        .LOCK_ON_DONE  (LOCK_ON),
        .LOCK_VALUE    (LOCKV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tbl_req    (tbl_req),
        .tbl_idx    (tbl_idx),
        .tbl_rvalid (tbl_rvalid),
        .tbl_data   (tbl_data),
        .cfg_write  (cfg_write),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .cfg_ready  (cfg_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .err_index  (err_index),
        .num_written(num_written)
    );

    always #5 clk = ~clk;

    // Environment: boot table, config register file and response modes.
    logic [47:0] tbl_mem [0:MAX-1];
    logic [31:0] regs [0:65535];
    bit          zero_wait, tbl_never, stall_first, stall_done;
    bit          corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = '0;
    int          stall_left = 0;
    int          tbl_wait = 0;
    int          tbl_delay = 0;
    bit          verify_on;

    assign cfg_rdata = (corrupt_en && cfg_addr == corrupt_addr) ? 32'hDEAD_BEEF : regs[cfg_addr];

    // Reference model results and observation counters.
    logic [47:0] exp_wr [$];
    logic        exp_done, exp_error;
    logic [1:0]  exp_code;
    int          exp_index, exp_num;
    int          busy_cycles, req_cycles;
    bit          lock_seen;
    logic [47:0] last_wr;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the table by the loader's rules and predict writes and final status.
    task automatic buildModel();
        exp_wr.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_code  = 2'd0;
        exp_index = 0;
        exp_num   = 0;
        if (tbl_never) begin
            exp_error = 1'b1;
            exp_code  = 2'd2;
            return;
        end
        for (int i = 0; i < MAX; i++) begin
            if (tbl_mem[i][47:32] == 16'hFFFF) begin
                if (LOCK_ON != 0) exp_wr.push_back({16'h0000, LOCKV});
                exp_done = 1'b1;
                return;
            end
            exp_wr.push_back(tbl_mem[i]);
            exp_num = i + 1;
            if (verify_on && corrupt_en && tbl_mem[i][47:32] == corrupt_addr
                && tbl_mem[i][31:0] != 32'hDEAD_BEEF) begin
                exp_error = 1'b1;
                exp_code  = 2'd1;
                exp_index = i;
                return;
            end
            if (i == MAX - 1) begin
                exp_error = 1'b1;
                exp_code  = 2'd3;
                exp_index = i;
                return;
            end
        end
    endtask

    task automatic fillTable(input int len);
        for (int i = 0; i < MAX; i++) begin
            if (i == len) tbl_mem[i] = {16'hFFFF, 32'($urandom)};
            else          tbl_mem[i] = {16'(i * 16 + $urandom_range(1, 15)), 32'($urandom)};
        end
    endtask

    // Called at posedge+3; start is sampled at the following edge.
    task automatic applyStimulus(input bit zw, input bit never, input bit stall);
        zero_wait   = zw;
        tbl_never   = never;
        stall_first = stall;
        stall_done  = 1'b0;
        buildModel();
        lock_seen   = 1'b0;
        busy_cycles = 0;
        req_cycles  = 0;
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit poke);
        bit finished = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #3;
            start = 1'b0;
            if (done || error) begin
                finished = 1'b1;
                break;
            end
            if (poke && busy && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        start = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_done: no done/error within %0d cycles", budget);
        end
    endtask

    task automatic checkFinal();
        checkOutput("done", done, exp_done);
        checkOutput("error", error, exp_error);
        checkOutput("err_code", err_code, exp_code);
        checkOutput("err_index", err_index, exp_index);
        checkOutput("num_written", num_written, exp_num);
        checkOutput("pending_writes", exp_wr.size(), 0);
        checkOutput("idle_outputs", {busy, tbl_req, cfg_write}, 3'b000);
    endtask

    // Drive responses on the falling edge, then compare against the model.
    initial begin
        logic        prev_stall = 1'b0;
        logic [15:0] prev_addr = '0;
        logic [31:0] prev_wdata = '0;
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (tbl_req) begin
                tbl_rvalid = !tbl_never && (tbl_wait >= tbl_delay);
                tbl_data   = tbl_mem[tbl_idx];
                tbl_wait++;
            end else begin
                tbl_rvalid = 1'b0;
                tbl_data   = '0;
                tbl_wait   = 0;
                tbl_delay  = zero_wait ? 0 : int'($urandom_range(0, 3));
            end
            if (stall_first && !stall_done && cfg_write) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                cfg_ready = 1'b0;
                stall_left--;
            end else begin
                cfg_ready = zero_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (busy) busy_cycles++;
            if (tbl_req) req_cycles++;
            checkOutput("busy_excl_status", busy && (done || error), 1'b0);
            checkOutput("done_excl_error", done && error, 1'b0);
            if (prev_stall)
                checkOutput("held_write", {cfg_write, cfg_addr, cfg_wdata}, {1'b1, prev_addr, prev_wdata});
            if (cfg_write && cfg_ready) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got %0h:%0h expected none", cfg_addr, cfg_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    checkOutput("write", {cfg_addr, cfg_wdata}, e);
                end
                regs[cfg_addr] = cfg_wdata;
                last_wr = {cfg_addr, cfg_wdata};
                if (cfg_addr == 16'h0000 && cfg_wdata == LOCKV) lock_seen = 1'b1;
            end
            prev_stall = cfg_write && !cfg_ready;
            prev_addr  = cfg_addr;
            prev_wdata = cfg_wdata;
        end
    end

    task automatic loadDirectedTable();
        for (int i = 0; i < MAX; i++) tbl_mem[i] = '0;
        tbl_mem[0] = {16'h0004, 32'h0000_0404};
        tbl_mem[1] = {16'h000C, 32'h0010_0410};
        tbl_mem[2] = {16'hFFFF, 32'h0000_0000};
    endtask

    initial begin
`ifdef COH_NOC_CFG_LOADER_VERIFY_EN
        verify_on = 1'b1;
`else
        verify_on = 1'b0;
`endif
        zero_wait = 1'b1;
        tbl_never = 1'b0;
        stall_first = 1'b0;
        stall_done = 1'b0;
        fillTable(MAX);
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_outputs",
            {tbl_req, tbl_idx, cfg_write, cfg_addr, cfg_wdata, busy, done, error, err_code, err_index, num_written}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #3;

        $display("[TB] directed table, zero wait");
        loadDirectedTable();
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(200, 1'b0);
        checkFinal();
        checkOutput("dir_num_written", num_written, 2);
        checkOutput("dir_done", done, 1'b1);
        checkOutput("dir_lock_write", last_wr, {16'h0000, 32'h0000_0005});
`ifdef COH_NOC_CFG_LOADER_VERIFY_EN
        checkOutput("dir_busy_cycles", busy_cycles, 8);
`else
        checkOutput("dir_busy_cycles", busy_cycles, 6);
`endif

        $display("[TB] stalled first write");
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitDone(200, 1'b0);
        checkFinal();
        checkOutput("stall_num_written", num_written, 2);
        checkOutput("stall_no_error", error, 1'b0);

        $display("[TB] corrupted readback on entry 1");
        corrupt_en   = 1'b1;
        corrupt_addr = 16'h000C;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(200, 1'b0);
        checkFinal();
`ifdef COH_NOC_CFG_LOADER_VERIFY_EN
        checkOutput("corrupt_err_code", err_code, 2'd1);
        checkOutput("corrupt_err_index", err_index, 1);
        checkOutput("corrupt_no_lock", lock_seen, 1'b0);
`else
        checkOutput("corrupt_ignored", done, 1'b1);
        checkOutput("corrupt_lock", lock_seen, 1'b1);
`endif
        corrupt_en = 1'b0;

        $display("[TB] table never responds");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitDone(200, 1'b0);
        checkFinal();
        checkOutput("timeout_err_code", err_code, 2'd2);
        checkOutput("timeout_req_cycles", req_cycles, 16);
        checkOutput("timeout_tbl_req", tbl_req, 1'b0);
        tbl_never = 1'b0;

        $display("[TB] table without terminator");
        fillTable(MAX);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(200, 1'b0);
        checkFinal();
        checkOutput("ovf_err_code", err_code, 2'd3);
        checkOutput("ovf_err_index", err_index, 7);
        checkOutput("ovf_num_written", num_written, 8);

        $display("[TB] reset during write");
        fillTable(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 50; n++) begin
                if (cfg_write) begin
                    seen = 1'b1;
                    break;
                end
                @(posedge clk);
                #3;
            end
            checkOutput("write_reached", seen, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
            {tbl_req, tbl_idx, cfg_write, cfg_addr, cfg_wdata, busy, done, error, err_code, err_index, num_written}, '0);
        start = 1'b1;
        @(posedge clk);
        #3;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        checkOutput("start_in_reset_ignored", busy, 1'b0);
        fillTable(4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDone(400, 1'b0);
        checkFinal();

        $display("[TB] randomized loads");
        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(0, MAX);
            fillTable(len);
            corrupt_en = (len > 0) && ($urandom_range(0, 3) == 0);
            if (corrupt_en) corrupt_addr = tbl_mem[$urandom_range(0, len - 1)][47:32];
            applyStimulus(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
            waitDone(400, 1'b1);
            checkFinal();
        end
        corrupt_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
